// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: shared definitions for the bit-serial ALU.
//   - ALU_control operation codes
//   - FSM state encoding and bit-slice operation encoding
//   - default operand width and the control decoder used by the top level
package alu_serial_pkg;

    localparam int unsigned DefaultWidth = 32;

    localparam logic [3:0] CtrlAnd = 4'b0000;
    localparam logic [3:0] CtrlOr  = 4'b0001;
    localparam logic [3:0] CtrlAdd = 4'b0010;
    localparam logic [3:0] CtrlSub = 4'b0110;
    localparam logic [3:0] CtrlSlt = 4'b0111;
    localparam logic [3:0] CtrlNor = 4'b1100;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        SliceAnd,
        SliceOr,
        SliceSum,
        SliceLess
    } slice_op_e;

    typedef struct packed {
        logic      supported;  // code is one of the six defined operations
        logic      a_invert;
        logic      b_invert;
        logic      arith;      // ADD/SUB/SLT: carry/overflow flags are meaningful
        logic      slt;
        slice_op_e op;
    } ctrl_dec_t;

    function automatic ctrl_dec_t decode_ctrl(logic [3:0] ctrl);
        ctrl_dec_t dec;
        dec = '{supported: 1'b0, a_invert: 1'b0, b_invert: 1'b0,
                arith: 1'b0, slt: 1'b0, op: SliceAnd};
        case (ctrl)
            CtrlAnd: begin
                dec.supported = 1'b1;
                dec.op        = SliceAnd;
            end
            CtrlOr: begin
                dec.supported = 1'b1;
                dec.op        = SliceOr;
            end
            CtrlAdd: begin
                dec.supported = 1'b1;
                dec.arith     = 1'b1;
                dec.op        = SliceSum;
            end
            CtrlSub: begin
                dec.supported = 1'b1;
                dec.b_invert  = 1'b1;
                dec.arith     = 1'b1;
                dec.op        = SliceSum;
            end
            CtrlSlt: begin
                dec.supported = 1'b1;
                dec.b_invert  = 1'b1;
                dec.arith     = 1'b1;
                dec.slt       = 1'b1;
                dec.op        = SliceSum;
            end
            CtrlNor: begin
                // De Morgan: ~(a | b) == ~a & ~b
                dec.supported = 1'b1;
                dec.a_invert  = 1'b1;
                dec.b_invert  = 1'b1;
                dec.op        = SliceAnd;
            end
            default: ;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: one-bit ALU slice, reused every cycle by the serial ALU.
// Ports:
//   a_i, b_i            operand bits
//   a_invert_i,
//   b_invert_i          invert operand bit before use
//   carry_i             carry in
//   less_i              value routed out for the SliceLess select
//   op_i                AND / OR / SUM / LESS select
//   result_o            selected result bit
//   sum_o               full-adder sum (available regardless of op_i)
//   carry_o             full-adder carry out
module alu_bit_slice
    import alu_serial_pkg::*;
(
    input  logic      a_i,
    input  logic      b_i,
    input  logic      a_invert_i,
    input  logic      b_invert_i,
    input  logic      carry_i,
    input  logic      less_i,
    input  slice_op_e op_i,
    output logic      result_o,
    output logic      sum_o,
    output logic      carry_o
);

    logic a_eff;
    logic b_eff;

    always_comb begin
        a_eff    = a_i ^ a_invert_i;
        b_eff    = b_i ^ b_invert_i;
        sum_o    = a_eff ^ b_eff ^ carry_i;
        carry_o  = (a_eff & b_eff) | (carry_i & (a_eff ^ b_eff));
        result_o = 1'b0;
        unique case (op_i)
            SliceAnd:  result_o = a_eff & b_eff;
            SliceOr:   result_o = a_eff | b_eff;
            SliceSum:  result_o = sum_o;
            SliceLess: result_o = less_i;
            default:   result_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// alu_serial: bit-serial ALU, one bit per clock through a single alu_bit_slice.
// Accepts a request in IDLE, spends WIDTH cycles in RUN (LSB first), then
// holds the result in DONE until out_ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready only in IDLE)
//   src1, src2          operands A and B
//   ALU_control         operation code (see alu_serial_pkg)
//   out_valid/out_ready result handshake
//   result, zero        result and result==0 flag
//   cout, overflow      MSB carry out / signed overflow (ADD, SUB, SLT only)
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    ctrl_dec_t        dec;
    ctrl_dec_t        in_dec;
    logic             slice_res;
    logic             slice_sum;
    logic             slice_carry;
    logic             last_bit;
    logic             msb_ovf;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] final_res;

    alu_bit_slice u_slice (
        .a_i        (a_q[cnt_q]),
        .b_i        (b_q[cnt_q]),
        .a_invert_i (dec.a_invert),
        .b_invert_i (dec.b_invert),
        .carry_i    (carry_q),
        .less_i     (1'b0),
        .op_i       (dec.op),
        .result_o   (slice_res),
        .sum_o      (slice_sum),
        .carry_o    (slice_carry)
    );

    always_comb begin
        dec      = decode_ctrl(ctrl_q);
        in_dec   = decode_ctrl(ALU_control);
        last_bit = (cnt_q == CntW'(WIDTH - 1));
        // On the MSB cycle carry_q is the carry into the MSB.
        msb_ovf  = carry_q ^ slice_carry;
        // Results enter at the MSB and move down; after WIDTH shifts bit i sits at i.
        shifted  = {slice_res, res_q[WIDTH-1:1]};

        if (!dec.supported) begin
            final_res = '0;
        end else if (dec.slt) begin
            final_res    = '0;
            final_res[0] = slice_sum ^ msb_ovf;
        end else begin
            final_res = shifted;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        res_d   = res_q;
        zero_d  = zero_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = src1;
                    b_d     = src2;
                    ctrl_d  = ALU_control;
                    cnt_d   = '0;
                    // B_invert doubles as the +1 of two's-complement subtraction.
                    carry_d = in_dec.b_invert;
                    state_d = StRun;
                end
            end
            StRun: begin
                carry_d = slice_carry;
                res_d   = shifted;
                if (last_bit) begin
                    res_d   = final_res;
                    zero_d  = (final_res == '0);
                    cout_d  = dec.arith & dec.supported & slice_carry;
                    ovf_d   = dec.arith & dec.supported & msb_ovf;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = res_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule
